// File: rtl/mem_map_pkg.sv
// Address-map constants and lane helpers shared by the
// data-side memory responder and its MMIO register bank.
package mem_map_pkg;

  localparam int MMIO_SEL_BIT = 15;

  localparam logic [2:0] OFF_CYCLE    = 3'd0;
  localparam logic [2:0] OFF_SCRATCH  = 3'd1;
  localparam logic [2:0] OFF_STORECNT = 3'd2;
  localparam logic [2:0] OFF_LASTADDR = 3'd3;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// Status/scratch register bank: free-running cycle counter,
// byte-writable scratch, saturating store counter, last address.
module mmio_regs
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        acc,
  input  logic        scr_we,
  input  logic [3:0]  be,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [2:0]  off,
  output logic [31:0] rd
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] storecnt_q, storecnt_d;
  logic [31:0] lastaddr_q, lastaddr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      scratch_q  <= '0;
      storecnt_q <= '0;
      lastaddr_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      storecnt_q <= storecnt_d;
      lastaddr_q <= lastaddr_d;
    end
  end

  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    scratch_d  = scratch_q;
    storecnt_d = storecnt_q;
    lastaddr_d = lastaddr_q;
    if (scr_we) scratch_d = lane_merge(scratch_q, wd, be);
    if (acc) begin
      lastaddr_d = a;
      // Counter sticks at all-ones rather than wrapping
      if (storecnt_q != '1) storecnt_d = storecnt_q + 32'd1;
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      OFF_CYCLE:    rd = cycle_q;
      OFF_SCRATCH:  rd = scratch_q;
      OFF_STORECNT: rd = storecnt_q;
      OFF_LASTADDR: rd = lastaddr_q;
      default:      rd = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus MMIO bank,
// byte-lane stores on clk, combinational full-word loads.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic          ram_sel;
  logic          acc;
  logic          ram_we;
  logic          scr_we;
  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic [31:0]   mmio_rd;

  always_comb begin
    ram_sel = !a[MMIO_SEL_BIT];
    idx     = a[AW+1:2];
    off     = a[4:2];
    acc     = we && (be != 4'b0000) &&
              (ram_sel || off == OFF_SCRATCH);
    // RAM has no reset, so a store under reset is gated here
    ram_we  = acc && ram_sel && !reset;
    scr_we  = acc && !ram_sel;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  mmio_regs u_mmio (
    .clk    (clk),
    .reset  (reset),
    .acc    (acc),
    .scr_we (scr_we),
    .be     (be),
    .a      (a),
    .wd     (wd),
    .off    (off),
    .rd     (mmio_rd)
  );

  assign rd = ram_sel ? mem_q[idx] : mmio_rd;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a
// word-level memory-map model.
module tb_data_mem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  int vectors;
  int miscompares;

  logic [31:0] m_ram [DEPTH];
  logic [31:0] m_cyc;
  logic [31:0] m_scr;
  logic [31:0] m_cnt;
  logic [31:0] m_last;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .be    (be),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] b
  );
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] ad);
    int off;
    if (ad[15] == 1'b0) return m_ram[(ad >> 2) % DEPTH];
    if (reset) return 32'h0;
    off = int'((ad >> 2) & 32'd7);
    case (off)
      0: return m_cyc;
      1: return m_scr;
      2: return m_cnt;
      3: return m_last;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    vectors++;
    assert (rd === exp) else begin
      miscompares++;
      $error("FAIL %s a=%h observed %h expected %h", tag, a, rd, exp);
    end
  endtask

  task automatic model_edge();
    bit ram_t;
    bit ok;
    ram_t = (a[15] == 1'b0);
    ok = we && (be != 4'b0) && (ram_t || ((a >> 2) & 32'd7) == 32'd1);
    if (reset) begin
      m_cyc = 0; m_scr = 0; m_cnt = 0; m_last = 0;
      return;
    end
    if (ok) begin
      if (ram_t)
        m_ram[(a >> 2) % DEPTH] = merge(m_ram[(a >> 2) % DEPTH], wd, be);
      else
        m_scr = merge(m_scr, wd, be);
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_last = a;
    end
    m_cyc = m_cyc + 1;
  endtask

  // Starts and ends on a falling edge; checks the pre-edge read.
  task automatic step(
    input string tag, input logic w, input logic [3:0] b,
    input logic [31:0] ad, input logic [31:0] d
  );
    we = w; be = b; a = ad; wd = d;
    #1;
    check(tag, model_rd(ad));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    vectors = 0;
    miscompares = 0;
    m_cyc = 0; m_scr = 0; m_cnt = 0; m_last = 0;
    reset = 1'b1; we = 1'b0; be = 4'h0; a = 32'h0; wd = 32'h0;

    #12;
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_8000 + 32'(i * 4);
      #1;
      check("reset_mmio_zero", 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step("idle", 1'b0, 4'h0, 32'h8000, 0);
    step("cycle_10", 1'b0, 4'h0, 32'h8000, 0);
    step("storecnt_0", 1'b0, 4'h0, 32'h8008, 0);

    for (int i = 0; i < DEPTH; i++)
      step("ram_init", 1'b1, 4'hF, 32'(i * 4), $urandom);

    step("st_full", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    step("rd_full", 1'b1, 4'h2, 32'h10, 32'h00AA_0000);
    step("rd_lane1", 1'b1, 4'h2, 32'h10, 32'h0000_5500);
    step("rd_55", 1'b0, 4'h0, 32'h10, 0);
    step("lastaddr", 1'b0, 4'h0, 32'h800C, 0);
    step("storecnt", 1'b0, 4'h0, 32'h8008, 0);

    step("be_zero", 1'b1, 4'h0, 32'h14, 32'hFFFF_FFFF);
    step("st_cycle", 1'b1, 4'hF, 32'h8000, 32'h1234_5678);
    for (int i = 2; i < 8; i++)
      step("st_ro", 1'b1, 4'hF, 32'h8000 + 32'(i * 4), $urandom);
    step("ram_14", 1'b0, 4'h0, 32'h14, 0);
    step("cycle_run", 1'b0, 4'h0, 32'h8000, 0);
    step("cnt_hold", 1'b0, 4'h0, 32'h8008, 0);

    step("scr_same", 1'b1, 4'hC, 32'h8004, 32'h1234_5678);
    step("scr_after", 1'b0, 4'h0, 32'h8004, 0);

    step("alias_st", 1'b1, 4'hF, 32'h10 + 32'(4 * DEPTH), 32'hCAFE_F00D);
    step("alias_rd", 1'b0, 4'h0, 32'h10, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if (i % 3 == 0) r[31:16] = 16'h0;
      step("random", 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), r, $urandom);
    end
    step("rnd_cnt", 1'b0, 4'h0, 32'h8008, 0);

    we = 1'b1; be = 4'hF; a = 32'h0000_0020; wd = 32'h5A5A_5A5A;
    reset = 1'b1;
    m_cyc = 0; m_scr = 0; m_cnt = 0; m_last = 0;
    a = 32'h8000;
    #1;
    check("async_rst", 32'h0);
    @(negedge clk);
    step("rst_store", 1'b1, 4'hF, 32'h20, 32'h5A5A_5A5A);
    reset = 1'b0;
    step("rst_ram_kept", 1'b0, 4'h0, 32'h20, 0);
    step("cyc_after_rst", 1'b0, 4'h0, 32'h8000, 0);
    step("cnt_after_rst", 1'b0, 4'h0, 32'h8008, 0);

    force dut.u_mmio.storecnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_mmio.storecnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step("sat_store", 1'b1, 4'hF, 32'h24, 32'h1111_2222);
    step("sat_store2", 1'b1, 4'h1, 32'h28, 32'h3333_4444);
    step("sat_cnt", 1'b0, 4'h0, 32'h8008, 0);
    step("sat_last", 1'b0, 4'h0, 32'h800C, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
